// File: rtl/xdma_ctrl_if.sv
// ============================================================================
// Module   : xdma_ctrl_if
// Brief    : Control-bus, memory-port and status bundle for the xdma_ctrl copy engine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_W
`define ADDR_W 9
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

interface xdma_ctrl_if #(
    parameter int AW = `ADDR_W - 1,
    parameter int DW = `DATA_W
);
    logic          ctrl_sel;
    logic          ctrl_we;
    logic [1:0]    ctrl_addr;
    logic [DW-1:0] ctrl_data_in;
    logic [DW-1:0] ctrl_data_out;
    logic          cpu_data_sel;
    logic          dma_sel;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_data_in;
    logic [DW-1:0] dma_data_out;
    logic          busy;
    logic          irq;

    // slave: the DMA controller; master: the CPU/memory environment around it
    modport slave (
        input  ctrl_sel, ctrl_we, ctrl_addr, ctrl_data_in, cpu_data_sel, dma_data_out,
        output ctrl_data_out, dma_sel, dma_we, dma_addr, dma_data_in, busy, irq
    );
    modport master (
        output ctrl_sel, ctrl_we, ctrl_addr, ctrl_data_in, cpu_data_sel, dma_data_out,
        input  ctrl_data_out, dma_sel, dma_we, dma_addr, dma_data_in, busy, irq
    );
endinterface

`default_nettype wire

// File: rtl/xdma_ctrl.sv
// ============================================================================
// Module   : xdma_ctrl
// Brief    : Single-channel word-copy DMA sharing the memory port with a CPU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_W
`define ADDR_W 9
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module xdma_ctrl #(
    parameter int LEN_W = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    xdma_ctrl_if.slave  bus
);
    localparam int AW = `ADDR_W - 1;
    localparam int DW = `DATA_W;

    localparam logic [1:0] C_REG_SRC    = 2'd0;
    localparam logic [1:0] C_REG_DST    = 2'd1;
    localparam logic [1:0] C_REG_LEN    = 2'd2;
    localparam logic [1:0] C_REG_STATUS = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [AW-1:0]     r_src, r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [DW-1:0]     r_buf;
    logic              r_done, r_irq;

    logic w_wr, w_cfg_wr, w_len_start, w_abort, w_clr_done;
    logic w_grant_wr, w_last;

    // Configuration writes only land while idle; STATUS writes are always accepted.
    assign w_wr        = bus.ctrl_sel && bus.ctrl_we;
    assign w_cfg_wr    = w_wr && (r_state == S_IDLE);
    assign w_len_start = w_cfg_wr && (bus.ctrl_addr == C_REG_LEN) &&
                         (bus.ctrl_data_in[LEN_W-1:0] != '0);
    assign w_abort     = w_wr && (bus.ctrl_addr == C_REG_STATUS) && bus.ctrl_data_in[1];
    assign w_clr_done  = w_wr && (bus.ctrl_addr == C_REG_STATUS) && bus.ctrl_data_in[0];
    assign w_grant_wr  = (r_state == S_WR) && !bus.cpu_data_sel;
    assign w_last      = w_grant_wr && (r_len == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.dma_sel     = 1'b0;
        bus.dma_we      = 1'b0;
        bus.dma_addr    = '0;
        bus.dma_data_in = '0;
        case (r_state)
            S_IDLE: begin
                if (w_len_start) w_state_nxt = S_RD;
            end
            S_RD: begin
                bus.dma_sel  = 1'b1;
                bus.dma_addr = r_src;
                if (!bus.cpu_data_sel) w_state_nxt = S_CAP;
            end
            S_CAP: begin
                w_state_nxt = S_WR;
            end
            S_WR: begin
                bus.dma_sel     = 1'b1;
                bus.dma_we      = 1'b1;
                bus.dma_addr    = r_dst;
                bus.dma_data_in = r_buf;
                if (w_grant_wr) w_state_nxt = w_last ? S_IDLE : S_RD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_buf  <= '0;
            r_done <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_cfg_wr && (bus.ctrl_addr == C_REG_SRC)) r_src <= bus.ctrl_data_in[AW-1:0];
            if (w_cfg_wr && (bus.ctrl_addr == C_REG_DST)) r_dst <= bus.ctrl_data_in[AW-1:0];
            if (w_len_start) begin
                r_len  <= bus.ctrl_data_in[LEN_W-1:0];
                r_done <= 1'b0;
            end
            if (r_state == S_CAP) r_buf <= bus.dma_data_out;
            if (w_grant_wr) begin
                r_src <= r_src + AW'(1);
                r_dst <= r_dst + AW'(1);
                r_len <= r_len - LEN_W'(1);
            end
            if (w_clr_done) r_done <= 1'b0;
            // An abort on the final write still lets the write land but hides completion.
            if (w_last && !w_abort) begin
                r_done <= 1'b1;
                r_irq  <= 1'b1;
            end
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.irq  = r_irq;

    always_comb begin
        bus.ctrl_data_out = '0;
        case (bus.ctrl_addr)
            C_REG_SRC:    bus.ctrl_data_out = DW'(r_src);
            C_REG_DST:    bus.ctrl_data_out = DW'(r_dst);
            C_REG_LEN:    bus.ctrl_data_out = DW'(r_len);
            C_REG_STATUS: bus.ctrl_data_out = DW'({r_done, bus.busy});
            default:      bus.ctrl_data_out = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_xdma_ctrl.sv
// ============================================================================
// Module   : tb_xdma_ctrl
// Brief    : Scoreboard bench for xdma_ctrl with a behavioural shared memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_W
`define ADDR_W 9
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module tb_xdma_ctrl;
    localparam int AW = `ADDR_W - 1;
    localparam int DW = `DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xdma_ctrl_if #(.AW(AW), .DW(DW)) bus();

    xdma_ctrl #(.LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata = '0;
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];

    assign bus.dma_data_out = r_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory: the CPU owns the port whenever cpu_data_sel is high.
    always @(posedge clk) begin
        if (bus.dma_sel && !bus.cpu_data_sel) begin
            if (bus.dma_we) mem[bus.dma_addr] <= bus.dma_data_in;
            else            r_rdata <= mem[bus.dma_addr];
        end
    end

    // Every granted write must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        if (rst_n && bus.dma_sel && bus.dma_we && !bus.cpu_data_sel) begin
            check("wr_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) begin
                check("wr_addr", 64'(bus.dma_addr), 64'(exp_addr_q.pop_front()));
                check("wr_data", 64'(bus.dma_data_in), 64'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic ctrl_write(input logic [1:0] a, input logic [DW-1:0] d);
        bus.ctrl_sel = 1'b1; bus.ctrl_we = 1'b1; bus.ctrl_addr = a; bus.ctrl_data_in = d;
        @(posedge clk); #1;
        bus.ctrl_sel = 1'b0; bus.ctrl_we = 1'b0; bus.ctrl_data_in = '0;
    endtask

    task automatic ctrl_read(input logic [1:0] a, output logic [DW-1:0] d);
        bus.ctrl_sel = 1'b1; bus.ctrl_we = 1'b0; bus.ctrl_addr = a;
        #1;
        d = bus.ctrl_data_out;
        bus.ctrl_sel = 1'b0;
    endtask

    task automatic expect_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n);
        logic [AW-1:0] s, t;
        s = src; t = dst;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(t);
            exp_data_q.push_back(mem[s]);
            s = s + AW'(1);
            t = t + AW'(1);
        end
    endtask

    // Called right after the LEN write; bit k of stall holds the CPU on the port in cycle k.
    task automatic run_cycles(input logic [31:0] stall, input int ncyc,
                              output int busy_cyc, output int irq_cnt);
        busy_cyc = 0; irq_cnt = 0;
        for (int k = 1; k <= ncyc; k++) begin
            bus.cpu_data_sel = (k < 32) ? stall[k] : 1'b0;
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.irq)  irq_cnt++;
            @(posedge clk); #1;
        end
        bus.cpu_data_sel = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        int bc, ic, sel_cnt;

        bus.ctrl_sel = 1'b0; bus.ctrl_we = 1'b0; bus.ctrl_addr = '0;
        bus.ctrl_data_in = '0; bus.cpu_data_sel = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(32'h5A00_0000 + i);
        mem[8'h10] = 32'hAAAA_0001; mem[8'h11] = 32'hBBBB_0002;
        mem[8'h12] = 32'hCCCC_0003; mem[8'h13] = 32'hDDDD_0004;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_irq", 64'(bus.irq), 64'd0);
        check("rst_dma_sel", 64'(bus.dma_sel), 64'd0);
        ctrl_read(2'd3, rd); check("rst_status", 64'(rd), 64'd0);
        ctrl_read(2'd2, rd); check("rst_len", 64'(rd), 64'd0);

        // Plain 4-word copy
        ctrl_write(2'd0, 32'h10);
        ctrl_write(2'd1, 32'h80);
        expect_copy(8'h10, 8'h80, 4);
        ctrl_write(2'd2, 32'd4);
        run_cycles(32'h0, 20, bc, ic);
        check("t1_busy_cycles", 64'(bc), 64'd12);
        check("t1_irq_pulses", 64'(ic), 64'd1);
        ctrl_read(2'd3, rd); check("t1_status", 64'(rd), 64'd2);
        check("t1_mem80", 64'(mem[8'h80]), 64'h0000_0000_AAAA_0001);
        check("t1_mem83", 64'(mem[8'h83]), 64'h0000_0000_DDDD_0004);
        ctrl_write(2'd3, 32'h1);
        ctrl_read(2'd3, rd); check("t1_done_clr", 64'(rd), 64'd0);

        // Same copy, CPU contends the first RD and the third WR cycle
        for (int i = 0; i < 4; i++) mem[8'h80 + i] = '0;
        ctrl_write(2'd0, 32'h10);
        ctrl_write(2'd1, 32'h80);
        expect_copy(8'h10, 8'h80, 4);
        ctrl_write(2'd2, 32'd4);
        run_cycles(32'h0000_0402, 22, bc, ic);
        check("t2_busy_cycles", 64'(bc), 64'd14);
        check("t2_irq_pulses", 64'(ic), 64'd1);
        check("t2_mem82", 64'(mem[8'h82]), 64'h0000_0000_CCCC_0003);

        // Address wrap on the source side
        mem[8'hFF] = 32'h1111_FFFF; mem[8'h00] = 32'h2222_0000;
        ctrl_write(2'd0, 32'hFF);
        ctrl_write(2'd1, 32'h20);
        expect_copy(8'hFF, 8'h20, 2);
        ctrl_write(2'd2, 32'd2);
        run_cycles(32'h0, 10, bc, ic);
        check("t3_busy_cycles", 64'(bc), 64'd6);
        check("t3_irq_pulses", 64'(ic), 64'd1);
        ctrl_read(2'd0, rd); check("t3_src_wrap", 64'(rd), 64'd1);
        ctrl_read(2'd1, rd); check("t3_dst", 64'(rd), 64'h22);
        check("t3_mem21", 64'(mem[8'h21]), 64'h0000_0000_2222_0000);

        // Abort after two granted writes; SRC write mid-transfer is ignored
        ctrl_write(2'd0, 32'h40);
        ctrl_write(2'd1, 32'hA0);
        expect_copy(8'h40, 8'hA0, 2);
        ctrl_write(2'd2, 32'd8);
        ctrl_write(2'd0, 32'h99);
        repeat (5) begin @(posedge clk); #1; end
        ctrl_write(2'd3, 32'h2);
        @(negedge clk);
        check("t4_busy_after_abort", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        run_cycles(32'h0, 8, bc, ic);
        check("t4_busy_idle", 64'(bc), 64'd0);
        check("t4_no_irq", 64'(ic), 64'd0);
        ctrl_read(2'd2, rd); check("t4_len", 64'(rd), 64'd6);
        ctrl_read(2'd0, rd); check("t4_src", 64'(rd), 64'h42);
        ctrl_read(2'd3, rd); check("t4_status", 64'(rd), 64'd0);

        // Reset during the first WR of a 3-word copy
        ctrl_write(2'd0, 32'h10);
        ctrl_write(2'd1, 32'h60);
        ctrl_write(2'd2, 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_in_wr", 64'(bus.dma_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_sel_async", 64'(bus.dma_sel), 64'd0);
        check("t5_busy_async", 64'(bus.busy), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        ctrl_read(2'd0, rd); check("t5_src", 64'(rd), 64'd0);
        ctrl_read(2'd1, rd); check("t5_dst", 64'(rd), 64'd0);
        ctrl_read(2'd2, rd); check("t5_len", 64'(rd), 64'd0);
        ctrl_read(2'd3, rd); check("t5_status", 64'(rd), 64'd0);
        @(posedge clk); #1;
        run_cycles(32'h0, 8, bc, ic);
        check("t5_no_irq", 64'(ic), 64'd0);

        // LEN=0 is a no-op
        ctrl_write(2'd2, 32'd0);
        sel_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.dma_sel || bus.busy) sel_cnt++;
        end
        check("t5_len0_idle", 64'(sel_cnt), 64'd0);
        check("t5_len0_mem60", 64'(mem[8'h60]), 64'(32'h5A00_0060));

        check("sb_drained", 64'(exp_addr_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
